// File: rtl/ysyx_22041405_pkg.sv
// Shared ALU encoding package: one-hot ALU operations, RV32I opcodes and
// funct3 codes, used by both the issue stage and the EXU ALU.
package ysyx_22041405_pkg;

  // One-hot ALU operation select, bit 7 down to bit 0
  localparam logic [7:0] ALU_NONE   = 8'b0000_0000;
  localparam logic [7:0] ALU_ADD    = 8'b1000_0000;
  localparam logic [7:0] ALU_LSHIFT = 8'b0100_0000;
  localparam logic [7:0] ALU_SLT    = 8'b0010_0000;
  localparam logic [7:0] ALU_RSHIFT = 8'b0001_0000;
  localparam logic [7:0] ALU_DIRECT = 8'b0000_1000;
  localparam logic [7:0] ALU_AND    = 8'b0000_0100;
  localparam logic [7:0] ALU_OR     = 8'b0000_0010;
  localparam logic [7:0] ALU_XOR    = 8'b0000_0001;

  // RV32I major opcodes handled by the ALU path
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct3 codes for OP / OP-IMM
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7 values that are legal on OP and on shift-immediates
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [7:0] opcode;
    logic       addOrSub;
    logic       uOrS;
  } alu_ctrl_t;

  // Map funct3 (plus the SUB/SRA alternate bit) onto the ALU control fields
  function automatic alu_ctrl_t aluCtrlFromFunct3(input logic [2:0] funct3, input logic alt);
    alu_ctrl_t c;
    c.opcode   = ALU_NONE;
    c.addOrSub = 1'b0;
    c.uOrS     = 1'b0;
    case (funct3)
      F3_ADD:  begin c.opcode = ALU_ADD; c.addOrSub = alt; end
      F3_SLL:  c.opcode = ALU_LSHIFT;
      F3_SLT:  begin c.opcode = ALU_SLT; c.addOrSub = 1'b1; end
      F3_SLTU: begin c.opcode = ALU_SLT; c.addOrSub = 1'b1; c.uOrS = 1'b1; end
      F3_XOR:  c.opcode = ALU_XOR;
      F3_SR:   begin c.opcode = ALU_RSHIFT; c.uOrS = ~alt; end
      F3_OR:   c.opcode = ALU_OR;
      default: c.opcode = ALU_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ysyx_22041405_imm_gen.sv
// Immediate extraction for the ALU issue stage: sign-extended I-type,
// U-type (upper 20 bits, low 12 zero) and zero-extended shift amount.
module ysyx_22041405_imm_gen #(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      inst_i,
  output logic [WIDTH-1:0] immI_o,
  output logic [WIDTH-1:0] immU_o,
  output logic [WIDTH-1:0] shamt_o
);

  assign immI_o  = WIDTH'($signed(inst_i[31:20]));
  assign immU_o  = WIDTH'($signed({inst_i[31:12], 12'b0}));
  assign shamt_o = WIDTH'(inst_i[24:20]);

endmodule

// File: rtl/ysyx_22041405_alu_issue.sv
// ALU decode-and-issue stage: decodes OP / OP-IMM / LUI / AUIPC, picks the
// operands and holds the resulting bundle in a single-entry output register.
module ysyx_22041405_alu_issue
  import ysyx_22041405_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  input  logic [WIDTH-1:0] rs1_rdata_i,
  input  logic [WIDTH-1:0] rs2_rdata_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] src1_o,
  output logic [WIDTH-1:0] src2_o,
  output logic [7:0]       alu_opcode_o,
  output logic             alu_add_or_sub_o,
  output logic             alu_U_or_S_o,
  output logic [4:0]       rd_o,
  output logic             rd_wen_o,
  output logic             illegal_o
);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             alt;
  logic             opLegal;
  logic             immLegal;
  alu_ctrl_t        ctrl;
  logic [WIDTH-1:0] immI, immU, shamt;

  logic [WIDTH-1:0] src1_d, src2_d, src1_q, src2_q;
  logic [7:0]       aluOpcode_d, aluOpcode_q;
  logic             addOrSub_d, addOrSub_q;
  logic             uOrS_d, uOrS_q;
  logic [4:0]       rd_d, rd_q;
  logic             rdWen_d, rdWen_q;
  logic             illegal_d, illegal_q;
  logic             outValid_q;
  logic             inFire, outFire;

  ysyx_22041405_imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
    .inst_i (inst_i),
    .immI_o (immI),
    .immU_o (immU),
    .shamt_o(shamt)
  );

  assign opcode     = inst_i[6:0];
  assign funct3     = inst_i[14:12];
  assign funct7     = inst_i[31:25];
  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];

  // inst[30] selects SUB/SRA on OP, but only SRAI on OP-IMM (elsewhere it is immediate)
  assign alt  = inst_i[30] && ((opcode == OPC_OP) || (funct3 == F3_SR));
  assign ctrl = aluCtrlFromFunct3(funct3, alt);

  // OP accepts the alternate funct7 only on ADD/SUB and SRL/SRA
  assign opLegal = (funct7 == F7_BASE) ||
                   ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));

  // Only the shift-immediates constrain the upper immediate bits
  assign immLegal = (funct3 == F3_SLL) ? (funct7 == F7_BASE) :
                    (funct3 == F3_SR)  ? ((funct7 == F7_BASE) || (funct7 == F7_ALT)) :
                                         1'b1;

  assign in_ready_o = !outValid_q || out_ready_i;
  assign inFire     = in_valid_i && in_ready_o;
  assign outFire    = outValid_q && out_ready_i;

  // Decode the incoming instruction into the next bundle; illegal by default
  always_comb begin
    src1_d      = '0;
    src2_d      = '0;
    aluOpcode_d = ALU_NONE;
    addOrSub_d  = 1'b0;
    uOrS_d      = 1'b0;
    rd_d        = inst_i[11:7];
    rdWen_d     = 1'b0;
    illegal_d   = 1'b1;
    case (opcode)
      OPC_OP: begin
        if (opLegal) begin
          src1_d      = rs1_rdata_i;
          src2_d      = rs2_rdata_i;
          aluOpcode_d = ctrl.opcode;
          addOrSub_d  = ctrl.addOrSub;
          uOrS_d      = ctrl.uOrS;
          rdWen_d     = 1'b1;
          illegal_d   = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        if (immLegal) begin
          src1_d      = rs1_rdata_i;
          src2_d      = ((funct3 == F3_SLL) || (funct3 == F3_SR)) ? shamt : immI;
          aluOpcode_d = ctrl.opcode;
          addOrSub_d  = ctrl.addOrSub;
          uOrS_d      = ctrl.uOrS;
          rdWen_d     = 1'b1;
          illegal_d   = 1'b0;
        end
      end
      OPC_LUI: begin
        src2_d      = immU;
        aluOpcode_d = ALU_DIRECT;
        rdWen_d     = 1'b1;
        illegal_d   = 1'b0;
      end
      OPC_AUIPC: begin
        src1_d      = pc_i;
        src2_d      = immU;
        aluOpcode_d = ALU_ADD;
        rdWen_d     = 1'b1;
        illegal_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // Output register: flush wins over a same-cycle load; data holds after drain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outValid_q  <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      aluOpcode_q <= '0;
      addOrSub_q  <= 1'b0;
      uOrS_q      <= 1'b0;
      rd_q        <= '0;
      rdWen_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (flush_i) begin
      outValid_q <= 1'b0;
    end else if (inFire) begin
      outValid_q  <= 1'b1;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      aluOpcode_q <= aluOpcode_d;
      addOrSub_q  <= addOrSub_d;
      uOrS_q      <= uOrS_d;
      rd_q        <= rd_d;
      rdWen_q     <= rdWen_d;
      illegal_q   <= illegal_d;
    end else if (outFire) begin
      outValid_q <= 1'b0;
    end
  end

  assign out_valid_o      = outValid_q;
  assign src1_o           = src1_q;
  assign src2_o           = src2_q;
  assign alu_opcode_o     = aluOpcode_q;
  assign alu_add_or_sub_o = addOrSub_q;
  assign alu_U_or_S_o     = uOrS_q;
  assign rd_o             = rd_q;
  assign rd_wen_o         = rdWen_q;
  assign illegal_o        = illegal_q;

endmodule

// File: tb/tb_ysyx_22041405_alu_issue.sv
// Self-checking bench for the ALU issue stage: directed cases from the
// instruction examples plus randomized traffic against a reference model.
module tb_ysyx_22041405_alu_issue;

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [7:0]  op;
    logic        aos;
    logic        uos;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] inst = '0;
  logic [31:0] pc = '0;
  logic [4:0]  rs1Addr, rs2Addr;
  logic [31:0] rs1Rdata = '0;
  logic [31:0] rs2Rdata = '0;
  logic        flush = 1'b0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [31:0] src1, src2;
  logic [7:0]  aluOpcode;
  logic        aluAddOrSub, aluUOrS;
  logic [4:0]  rd;
  logic        rdWen, illegal;

  int total = 0;
  int bad = 0;

  ysyx_22041405_alu_issue #(.WIDTH(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_valid_i      (inValid),
    .in_ready_o      (inReady),
    .inst_i          (inst),
    .pc_i            (pc),
    .rs1_addr_o      (rs1Addr),
    .rs2_addr_o      (rs2Addr),
    .rs1_rdata_i     (rs1Rdata),
    .rs2_rdata_i     (rs2Rdata),
    .flush_i         (flush),
    .out_valid_o     (outValid),
    .out_ready_i     (outReady),
    .src1_o          (src1),
    .src2_o          (src2),
    .alu_opcode_o    (aluOpcode),
    .alu_add_or_sub_o(aluAddOrSub),
    .alu_U_or_S_o    (aluUOrS),
    .rd_o            (rd),
    .rd_wen_o        (rdWen),
    .illegal_o       (illegal)
  );

  always #5 clk = ~clk;

  function automatic bundle_t dutBundle();
    return {src1, src2, aluOpcode, aluAddOrSub, aluUOrS, rd, rdWen, illegal};
  endfunction

  function automatic bundle_t mk(input logic [31:0] s1, input logic [31:0] s2, input logic [7:0] op,
                                 input logic aos, input logic uos, input logic [4:0] r,
                                 input logic wen, input logic ill);
    return {s1, s2, op, aos, uos, r, wen, ill};
  endfunction

  // Reference decode, written mnemonic by mnemonic from the instruction set rules
  function automatic bundle_t refModel(input logic [31:0] w, input logic [31:0] p,
                                       input logic [31:0] a, input logic [31:0] b);
    bundle_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] immI, immU, shamt;
    bit ok, isImm;
    opc   = w[6:0];
    f3    = w[14:12];
    f7    = w[31:25];
    immI  = {{20{w[31]}}, w[31:20]};
    immU  = {w[31:12], 12'h000};
    shamt = {27'd0, w[24:20]};
    e = '0;
    e.rd = w[11:7];
    ok = 1;
    if (opc == 7'h37) begin
      e.op = 8'h08; e.src2 = immU;
    end else if (opc == 7'h17) begin
      e.op = 8'h80; e.src1 = p; e.src2 = immU;
    end else if (opc == 7'h33 || opc == 7'h13) begin
      isImm = (opc == 7'h13);
      e.src1 = a;
      e.src2 = isImm ? immI : b;
      case (f3)
        3'd0: begin
          e.op = 8'h80;
          if (!isImm && f7 == 7'h20) e.aos = 1;
          else if (!isImm && f7 != 7'h00) ok = 0;
        end
        3'd1: begin e.op = 8'h40; ok = (f7 == 7'h00); if (isImm) e.src2 = shamt; end
        3'd2: begin e.op = 8'h20; e.aos = 1; ok = isImm || f7 == 7'h00; end
        3'd3: begin e.op = 8'h20; e.aos = 1; e.uos = 1; ok = isImm || f7 == 7'h00; end
        3'd4: begin e.op = 8'h01; ok = isImm || f7 == 7'h00; end
        3'd5: begin
          e.op = 8'h10;
          if (f7 == 7'h00) e.uos = 1;
          else if (f7 != 7'h20) ok = 0;
          if (isImm) e.src2 = shamt;
        end
        3'd6: begin e.op = 8'h02; ok = isImm || f7 == 7'h00; end
        default: begin e.op = 8'h04; ok = isImm || f7 == 7'h00; end
      endcase
    end else begin
      ok = 0;
    end
    if (ok) e.wen = 1;
    else e = mk(32'd0, 32'd0, 8'h00, 1'b0, 1'b0, w[11:7], 1'b0, 1'b1);
    return e;
  endfunction

  // Mostly ALU-class encodings, some with odd funct7, some random opcodes
  function automatic logic [31:0] randInst();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k <= 3) begin
      w[6:0] = 7'h33;
      if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    end else if (k <= 6) begin
      w[6:0] = 7'h13;
      if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    end else if (k == 7) begin
      w[6:0] = 7'h37;
    end else if (k == 8) begin
      w[6:0] = 7'h17;
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyOne(input logic [31:0] w, input logic [31:0] p,
                          input logic [31:0] a, input logic [31:0] b);
    inValid = 1'b1; inst = w; pc = p; rs1Rdata = a; rs2Rdata = b;
    tick();
    inValid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; inValid = 1'b0; outReady = 1'b1; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", outValid); end
    total++; if (dutBundle() !== bundle_t'(0)) begin bad++; $display("[TB] FAIL reset_bundle: got %h want 0", dutBundle()); end
    total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", inReady); end
    inst = 32'h402081B3; #1;
    total++;
    if (rs1Addr !== 5'd1 || rs2Addr !== 5'd2) begin
      bad++; $display("[TB] FAIL rs_addr: got %0d/%0d want 1/2", rs1Addr, rs2Addr);
    end
  endtask

  task automatic test_directed();
    bundle_t exp;
    outReady = 1'b1;
    applyOne(32'h00500093, 32'h0, 32'h0, 32'h0);
    exp = mk(32'd0, 32'd5, 8'h80, 0, 0, 5'd1, 1, 0);
    total++; if (outValid !== 1'b1 || dutBundle() !== exp) begin bad++; $display("[TB] FAIL addi: got v=%b %h want v=1 %h", outValid, dutBundle(), exp); end
    applyOne(32'h402081B3, 32'h0, 32'd9, 32'd4);
    exp = mk(32'd9, 32'd4, 8'h80, 1, 0, 5'd3, 1, 0);
    total++; if (outValid !== 1'b1 || dutBundle() !== exp) begin bad++; $display("[TB] FAIL sub: got v=%b %h want v=1 %h", outValid, dutBundle(), exp); end
    applyOne(32'h40335293, 32'h0, 32'hF000_0000, 32'h1234);
    exp = mk(32'hF000_0000, 32'd3, 8'h10, 0, 0, 5'd5, 1, 0);
    total++; if (dutBundle() !== exp) begin bad++; $display("[TB] FAIL srai: got %h want %h", dutBundle(), exp); end
    applyOne(32'hFFF4B413, 32'h0, 32'h77, 32'h0);
    exp = mk(32'h77, 32'hFFFF_FFFF, 8'h20, 1, 1, 5'd8, 1, 0);
    total++; if (dutBundle() !== exp) begin bad++; $display("[TB] FAIL sltiu: got %h want %h", dutBundle(), exp); end
    applyOne(32'h123453B7, 32'h0, 32'hDEAD_BEEF, 32'h0);
    exp = mk(32'd0, 32'h1234_5000, 8'h08, 0, 0, 5'd7, 1, 0);
    total++; if (dutBundle() !== exp) begin bad++; $display("[TB] FAIL lui: got %h want %h", dutBundle(), exp); end
    applyOne(32'h00001517, 32'h8000_0000, 32'h5, 32'h6);
    exp = mk(32'h8000_0000, 32'h0000_1000, 8'h80, 0, 0, 5'd10, 1, 0);
    total++; if (dutBundle() !== exp) begin bad++; $display("[TB] FAIL auipc: got %h want %h", dutBundle(), exp); end
    tick();
    total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL drain: got %b want 0", outValid); end
  endtask

  task automatic test_backpressure();
    bundle_t held;
    outReady = 1'b1;
    applyOne(32'h00500093, 32'h0, 32'h0, 32'h0);
    held = mk(32'd0, 32'd5, 8'h80, 0, 0, 5'd1, 1, 0);
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1; inst = 32'h402081B3; rs1Rdata = $urandom; rs2Rdata = $urandom;
      #1;
      total++; if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready[%0d]: got %b want 0", i, inReady); end
      tick();
      total++;
      if (outValid !== 1'b1 || dutBundle() !== held) begin
        bad++; $display("[TB] FAIL stall_hold[%0d]: got v=%b %h want v=1 %h", i, outValid, dutBundle(), held);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [3];
    bundle_t exp;
    insts[0] = 32'h402081B3; insts[1] = 32'h40335293; insts[2] = 32'h123453B7;
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1; inst = insts[i]; rs1Rdata = 32'd9 + i; rs2Rdata = 32'd4;
      #1;
      total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL b2b_in_ready[%0d]: got %b want 1", i, inReady); end
      exp = refModel(insts[i], pc, 32'd9 + i, 32'd4);
      tick();
      total++;
      if (outValid !== 1'b1 || dutBundle() !== exp) begin
        bad++; $display("[TB] FAIL b2b[%0d]: got v=%b %h want v=1 %h", i, outValid, dutBundle(), exp);
      end
    end
    inValid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    bundle_t exp;
    logic [31:0] badInsts [2];
    outReady = 1'b1;
    applyOne(32'h0000_0000, 32'h0, 32'h11, 32'h22);
    exp = mk(32'd0, 32'd0, 8'h00, 0, 0, 5'd0, 0, 1);
    total++; if (outValid !== 1'b1 || dutBundle() !== exp) begin bad++; $display("[TB] FAIL illegal_zero: got v=%b %h want v=1 %h", outValid, dutBundle(), exp); end
    badInsts[0] = 32'h0220_8133;
    badInsts[1] = 32'h4010_9093;
    for (int i = 0; i < 2; i++) begin
      applyOne(badInsts[i], 32'h0, 32'h33, 32'h44);
      total++;
      if (outValid !== 1'b1 || illegal !== 1'b1 || aluOpcode !== 8'h00 || rdWen !== 1'b0 ||
          src1 !== 32'd0 || src2 !== 32'd0) begin
        bad++; $display("[TB] FAIL illegal_funct7[%0d]: got ill=%b op=%h wen=%b s1=%h s2=%h want 1/00/0/0/0",
                        i, illegal, aluOpcode, rdWen, src1, src2);
      end
    end
    tick();
  endtask

  task automatic test_flush();
    outReady = 1'b1;
    applyOne(32'h00500093, 32'h0, 32'h0, 32'h0);
    inValid = 1'b1; inst = 32'h402081B3; flush = 1'b1;
    tick();
    flush = 1'b0; inValid = 1'b0;
    total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL flush_with_input: got %b want 0", outValid); end
    applyOne(32'h00500093, 32'h0, 32'h0, 32'h0);
    outReady = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (outValid !== 1'b0 || inReady !== 1'b1) begin bad++; $display("[TB] FAIL flush_stall: got v=%b rdy=%b want 0/1", outValid, inReady); end
    outReady = 1'b1;
  endtask

  task automatic test_reset_stall();
    outReady = 1'b1;
    applyOne(32'h123453B7, 32'h0, 32'h0, 32'h0);
    outReady = 1'b0; inValid = 1'b1; inst = 32'h402081B3;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; inValid = 1'b0; outReady = 1'b1;
    total++;
    if (outValid !== 1'b0 || dutBundle() !== bundle_t'(0) || inReady !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_stall: got v=%b %h rdy=%b want 0 0 1", outValid, dutBundle(), inReady);
    end
  endtask

  task automatic test_random();
    bit mv;
    bundle_t mb, act, exp;
    bit fire;
    mv = 0;
    mb = '0;
    for (int i = 0; i < 400; i++) begin
      inValid  = ($urandom_range(0, 9) < 7);
      outReady = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 19) == 0);
      inst     = randInst();
      pc       = $urandom & 32'hFFFF_FFFC;
      rs1Rdata = $urandom;
      rs2Rdata = $urandom;
      #1;
      total++;
      if (inReady !== (!mv || outReady)) begin
        bad++; $display("[TB] FAIL rand_in_ready[%0d]: got %b want %b", i, inReady, (!mv || outReady));
      end
      total++;
      if (rs1Addr !== inst[19:15] || rs2Addr !== inst[24:20]) begin
        bad++; $display("[TB] FAIL rand_rs_addr[%0d]: got %0d/%0d want %0d/%0d", i, rs1Addr, rs2Addr, inst[19:15], inst[24:20]);
      end
      fire = inValid && (!mv || outReady);
      if (flush) mv = 0;
      else if (fire) begin mb = refModel(inst, pc, rs1Rdata, rs2Rdata); mv = 1; end
      else if (mv && outReady) mv = 0;
      tick();
      total++;
      if (outValid !== mv) begin
        bad++; $display("[TB] FAIL rand_valid[%0d]: got %b want %b", i, outValid, mv);
      end
      if (mv) begin
        act = dutBundle();
        exp = mb;
        if (exp.ill) begin act.rd = '0; exp.rd = '0; end
        total++;
        if (act !== exp) begin
          bad++; $display("[TB] FAIL rand_bundle[%0d]: got %h want %h", i, act, exp);
        end
      end
    end
    inValid = 1'b0; flush = 1'b0; outReady = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22041405_alu_issue.md
# ysyx_22041405_alu_issue

Decode-and-issue stage that produces the operand and control bundle consumed by the EXU ALU: `src1`, `src2`, the one-hot `alu_opcode`, `alu_add_or_sub` and `alu_U_or_S`. It accepts RV32I instructions from the IFU over a valid/ready handshake and reads the register file combinationally. It decodes the ALU-class instructions (OP, OP-IMM, LUI, AUIPC) and presents the result to the EXU from a single-entry output register with its own valid/ready handshake.

## Interface
- WIDTH, 32, datapath width of operands and PC.
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  IFU has an instruction.
- in_ready  out  1  stage can accept; equals `!out_valid || out_ready`.
- inst  in  32  instruction word.
- pc  in  WIDTH  address of `inst`.
- rs1_addr, rs2_addr  out  5 each  combinational from `inst[19:15]` and `inst[24:20]`.
- rs1_rdata, rs2_rdata  in  WIDTH each  register file read data, same cycle.
- flush  in  1  discard the held entry and any same-cycle input.
- out_valid  out  1  bundle valid toward EXU.
- out_ready  in  1  EXU accepts.
- src1, src2  out  WIDTH  ALU operands.
- alu_opcode  out  8  one-hot, bit order {ADD, LSHIFT, SLT, RSHIFT, DIRECT, AND, OR, XOR} from bit 7 down to bit 0.
- alu_add_or_sub  out  1  0 = add, 1 = subtract.
- alu_U_or_S  out  1  1 = unsigned/logical, 0 = signed/arithmetic.
- rd  out  5  destination register.
- rd_wen  out  1  write-back enable.
- illegal  out  1  instruction is not ALU-class.

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- On an input transfer without flush: decode `inst` and register all outputs; `out_valid <= 1`.
- On an output transfer with no input transfer: `out_valid <= 0`. Data outputs hold their last value.
- Decode rules:
  - ADD/ADDI: ADD; `add_or_sub = 0`.
  - SUB: ADD; `add_or_sub = 1`.
  - SLL/SLLI: LSHIFT.
  - SLT/SLTI: SLT; `add_or_sub = 1`; `U_or_S = 0`.
  - SLTU/SLTIU: SLT; `add_or_sub = 1`; `U_or_S = 1`.
  - SRL/SRLI: RSHIFT; `U_or_S = 1`.
  - SRA/SRAI: RSHIFT; `U_or_S = 0`.
  - AND/ANDI, OR/ORI, XOR/XORI: AND, OR, XOR respectively.
  - LUI: DIRECT; `src2 = imm`.
  - AUIPC: ADD; `src1 = pc`; `src2 = imm`.
- Operand selection:
  - OP: `src1 = rs1_rdata`, `src2 = rs2_rdata`.
  - OP-IMM: `src1 = rs1_rdata`, `src2 = sign-extended I-imm`.
  - Shift-immediate: `src2 = zero-extended shamt inst[24:20]`.
  - LUI: `src1 = 0`.
- `alu_add_or_sub` and `alu_U_or_S` are 0 wherever not listed above.
- `rd_wen = 1` for every legal instruction, including `rd = 0`. The register file ignores writes to x0.
- Illegal instructions are any opcode outside the set above, or a bad funct7 for OP or shift-immediate. For these:
  - `alu_opcode = 0`, `rd_wen = 0`, `illegal = 1`, `src1 = src2 = 0`.
  - The instruction is still handshaked through.
- `flush` clears `out_valid` at the next edge. It overrides a simultaneous input transfer; that instruction is dropped and the IFU must treat it as consumed.

## Timing
- Latency is 1 cycle from input transfer to `out_valid`.
- Throughput is 1 per cycle when `out_ready` is held high.
- While `out_valid && !out_ready`: `in_ready = 0`, and all outputs are held stable.
- A simultaneous output transfer and input transfer loads the new bundle with no bubble.
- Reset: `out_valid = 0` and all registered outputs are 0. `in_ready` is 1 in the first cycle after reset.
- Reset asserted mid-stall clears the held bundle. No transfer occurs in a reset cycle.
- `rs1_addr`/`rs2_addr` are purely combinational and have no reset value of their own.

## Structure
- Shared package `ysyx_22041405_pkg` holds:
  - the eight ALU one-hot constants;
  - RV32I opcode constants (OP, OP_IMM, LUI, AUIPC);
  - funct3 codes.
- The EXU ALU imports the same package.
- Sub-module `ysyx_22041405_imm_gen`: combinational I/U immediate and shamt extraction.
- The top module holds the decode and the output register.

## Test plan
- `addi x1,x0,5` (0x00500093), `rs1_rdata = 0`: next cycle `out_valid = 1`, `alu_opcode = 8'b10000000`, `src1 = 0`, `src2 = 5`, `add_or_sub = 0`, `rd = 1`, `rd_wen = 1`.
- `sub x3,x1,x2` (0x402081B3), `rs1_rdata = 9`, `rs2_rdata = 4`: `alu_opcode = 8'h80`, `add_or_sub = 1`, `src1 = 9`, `src2 = 4`, `rd = 3`.
- `srai x5,x6,3` (0x40335293): `alu_opcode = 8'h10`, `U_or_S = 0`, `src2 = 3`. Then `sltiu x8,x9,-1` (0xFFF4B413): `alu_opcode = 8'h20`, `U_or_S = 1`, `add_or_sub = 1`, `src2 = 0xFFFFFFFF`.
- `lui x7,0x12345` (0x123453B7): `alu_opcode = 8'h08`, `src1 = 0`, `src2 = 0x12345000`. `auipc` with `pc = 0x80000000` and imm 0x1: `src1 = 0x80000000`, `src2 = 0x00001000`, opcode ADD.
- Backpressure:
  - Hold `out_ready = 0` for 3 cycles after an issue: `in_ready = 0` and outputs stable throughout.
  - Raise `out_ready` with `in_valid` high: back-to-back transfers with no bubble.
  - Inst 0x00000000: `illegal = 1`, `alu_opcode = 0`, `rd_wen = 0`.
- Assert `flush` in the same cycle as an input transfer: `out_valid = 0` next cycle. Assert `rst` during a stall: all outputs 0 and `in_ready = 1` next cycle.
